// File: rtl/int_ctl_pkg.sv
// Shared definitions for the interrupt controller and its claim sequencer:
// register offsets inside the controller window, the claim FSM states and
// small helpers used to build masks and clear words.
package int_ctl_pkg;

  // Register offsets relative to the controller base address.
  localparam logic [31:0] INT_EN_OFF   = 32'h0000_0000;
  localparam logic [31:0] INT_PEND_OFF = 32'h0000_0004;

  // Saturation ceiling of the spurious-claim counter.
  localparam logic [7:0] SPUR_MAX = 8'hFF;

  // Claim sequencer FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_PEND = 3'd1,
    WT_PEND = 3'd2,
    RD_EN   = 3'd3,
    WT_EN   = 3'd4,
    DECIDE  = 3'd5,
    CLR     = 3'd6,
    PRESENT = 3'd7
  } claim_state_e;

  // Mask with the low n bits set (n in 1..32).
  function automatic logic [31:0] src_mask(input int n);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // One-hot word for a source index, used as the write-1-to-clear value.
  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'h1 << idx;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Simple single-beat register bus between the claim sequencer and the
// interrupt controller.
//
// Handshake: the initiator raises valid with w_en/addr/w_data and holds
// them unchanged until it sees ready=1; the transfer happens in the cycle
// where valid && ready. For a read (w_en=0) the target presents r_data in
// the following cycle, where the initiator samples it. w_en and w_data
// carry no meaning while valid=0.
interface mem_if;
  logic        valid;
  logic        w_en;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic        ready;
  logic [31:0] r_data;

  modport initiator (
    output valid,
    output w_en,
    output addr,
    output w_data,
    input  ready,
    input  r_data
  );

  modport target (
    input  valid,
    input  w_en,
    input  addr,
    input  w_data,
    output ready,
    output r_data
  );
endinterface

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (bit 0 wins).
module int_prio_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             found_o,
  output logic [4:0]       index_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found_o = 1'b0;
    index_o = 5'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        index_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/int_claim_sequencer.sv
// Claim sequencer: on an interrupt request it reads the controller's
// pending and enable registers, picks the highest-priority enabled pending
// source, clears it in the controller (write-1-to-clear) and then presents
// the claimed ID to the core until the core accepts it. Attempts that find
// nothing to claim are counted as spurious.
module int_claim_sequencer
  import int_ctl_pkg::*;
#(
  parameter int          NUM_INT_SRCS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_int,
  mem_if.initiator   if_mem,
  output logic       o_claim_valid,
  output logic [4:0] o_claim_id,
  input  logic       i_claim_ready,
  output logic [7:0] o_spurious_cnt,
  output logic [2:0] o_dbg_state
);

  if (NUM_INT_SRCS < 1 || NUM_INT_SRCS > 32) begin : g_bad_num_srcs
    $error("int_claim_sequencer: NUM_INT_SRCS must be in 1..32");
  end

  // Bits above NUM_INT_SRCS are forced to zero here, so the encoder can
  // never select a source that does not exist.
  localparam logic [31:0] SRC_MASK = src_mask(NUM_INT_SRCS);

  claim_state_e state_q, state_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  en_q, en_d;
  logic [4:0]   id_q, id_d;
  logic [7:0]   spur_q, spur_d;

  logic [31:0]  masked;
  logic         enc_found;
  logic [4:0]   enc_index;

  assign masked = pend_q & en_q & SRC_MASK;

  int_prio_enc #(
    .WIDTH (32)
  ) u_prio_enc (
    .req_i   (masked),
    .found_o (enc_found),
    .index_o (enc_index)
  );

  // State and captured-register update; reset aborts any bus transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pend_q  <= 32'h0;
      en_q    <= 32'h0;
      id_q    <= 5'd0;
      spur_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      id_q    <= id_d;
      spur_q  <= spur_d;
    end
  end

  // Next-state logic and bus/claim outputs for each state.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    en_d          = en_q;
    id_d          = id_q;
    spur_d        = spur_q;
    if_mem.valid  = 1'b0;
    if_mem.w_en   = 1'b0;
    if_mem.addr   = BASE_ADDR;
    if_mem.w_data = 32'h0;
    o_claim_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_int) state_d = RD_PEND;
      end
      RD_PEND: begin
        if_mem.valid = 1'b1;
        if_mem.addr  = BASE_ADDR + INT_PEND_OFF;
        if (if_mem.ready) state_d = WT_PEND;
      end
      WT_PEND: begin
        pend_d  = if_mem.r_data;
        state_d = RD_EN;
      end
      RD_EN: begin
        if_mem.valid = 1'b1;
        if_mem.addr  = BASE_ADDR + INT_EN_OFF;
        if (if_mem.ready) state_d = WT_EN;
      end
      WT_EN: begin
        en_d    = if_mem.r_data;
        state_d = DECIDE;
      end
      DECIDE: begin
        if (enc_found) begin
          id_d    = enc_index;
          state_d = CLR;
        end else begin
          if (spur_q != SPUR_MAX) spur_d = spur_q + 8'd1;
          state_d = IDLE;
        end
      end
      CLR: begin
        if_mem.valid  = 1'b1;
        if_mem.w_en   = 1'b1;
        if_mem.addr   = BASE_ADDR + INT_PEND_OFF;
        if_mem.w_data = onehot32(id_q);
        if (if_mem.ready) state_d = PRESENT;
      end
      PRESENT: begin
        o_claim_valid = 1'b1;
        if (i_claim_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_claim_id     = id_q;
  assign o_spurious_cnt = spur_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_int_claim_sequencer.sv
// Directed bench for int_claim_sequencer with a small behavioural model of
// the interrupt controller register window (enable + write-1-to-clear
// pending) answering on mem_if.
module tb_int_claim_sequencer;
  import int_ctl_pkg::*;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'h4000_1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       int_i;
  logic       claim_ready;
  logic       claim_valid;
  logic [4:0] claim_id;
  logic [7:0] spur;
  logic [2:0] dbg;

  mem_if bus ();

  int_claim_sequencer #(
    .NUM_INT_SRCS (NSRC),
    .BASE_ADDR    (BASE)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_int          (int_i),
    .if_mem         (bus),
    .o_claim_valid  (claim_valid),
    .o_claim_id     (claim_id),
    .i_claim_ready  (claim_ready),
    .o_spurious_cnt (spur),
    .o_dbg_state    (dbg)
  );

  // ---------------- controller model ----------------
  logic        mem_ready;
  logic        ld_go;
  logic [31:0] ld_en, ld_pend;
  logic [31:0] m_en = 32'h0;
  logic [31:0] m_pend = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  int          req_cnt = 0;

  assign bus.ready = mem_ready;

  always @(posedge clk) begin
    if (ld_go) begin
      m_en   <= ld_en;
      m_pend <= ld_pend;
    end
    if (bus.valid && bus.ready) begin
      req_cnt <= req_cnt + 1;
      if (bus.w_en) begin
        last_wr_addr <= bus.addr;
        last_wr_data <= bus.w_data;
        if (bus.addr == BASE + INT_PEND_OFF) m_pend <= m_pend & ~bus.w_data;
        else if (bus.addr == BASE + INT_EN_OFF) m_en <= bus.w_data;
      end else begin
        bus.r_data <= (bus.addr == BASE + INT_EN_OFF) ? m_en : m_pend;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ctl_load(input logic [31:0] en, input logic [31:0] pend);
    ld_en   = en;
    ld_pend = pend;
    ld_go   = 1'b1;
    @(negedge clk);
    ld_go   = 1'b0;
  endtask

  // Pulse i_int for one cycle, optionally stall the pending read for
  // 'stall' cycles, and count negedges until the claim is presented.
  task automatic run_claim(input int stall, output int lat);
    lat       = 0;
    int_i     = 1'b1;
    mem_ready = (stall == 0);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) int_i = 1'b0;
      if (stall > 0 && n <= stall + 1) begin
        chk("stall_valid", {31'h0, bus.valid}, 32'h1);
        chk("stall_wen", {31'h0, bus.w_en}, 32'h0);
        chk("stall_addr", bus.addr, BASE + INT_PEND_OFF);
      end
      if (n == stall + 1) mem_ready = 1'b1;
      if (claim_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("claim_timeout", {31'h0, claim_valid}, 32'h1);
  endtask

  task automatic wait_claim();
    for (int n = 0; n < 30; n++) begin
      if (claim_valid) break;
      @(negedge clk);
    end
    chk("wait_claim", {31'h0, claim_valid}, 32'h1);
  endtask

  // Compare the presented ID against the scoreboard, then accept it.
  task automatic accept_claim();
    logic [4:0] exp_id;
    exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1F;
    chk("claim_id", {27'h0, claim_id}, {27'h0, exp_id});
    claim_ready = 1'b1;
    @(negedge clk);
    claim_ready = 1'b0;
    chk("claim_drop", {31'h0, claim_valid}, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int rc;
    logic seen;

    rst = 1'b1; int_i = 1'b0; claim_ready = 1'b0; mem_ready = 1'b1;
    ld_go = 1'b0; ld_en = 32'h0; ld_pend = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_state", {29'h0, dbg}, {29'h0, IDLE});
    chk("rst_valid", {31'h0, bus.valid}, 32'h0);
    chk("rst_claim_valid", {31'h0, claim_valid}, 32'h0);
    chk("rst_claim_id", {27'h0, claim_id}, 32'h0);
    chk("rst_spur", {24'h0, spur}, 32'h0);
    rst = 1'b0;

    // Basic claim: en=pend=0C -> ID 2, clear word 4, pending left at 08.
    ctl_load(32'h0C, 32'h0C);
    exp_q.push_back(5'd2);
    run_claim(0, lat);
    chk("lat_base", lat, 7);
    chk("clr_addr", last_wr_addr, BASE + INT_PEND_OFF);
    chk("clr_data", last_wr_data, 32'h4);
    accept_claim();
    chk("pend_after", m_pend, 32'h08);
    chk("idle_after", {29'h0, dbg}, {29'h0, IDLE});

    // Spurious: en=01, pend=02 with i_int held high.
    ctl_load(32'h01, 32'h02);
    int_i = 1'b1;
    seen  = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      seen = seen | claim_valid;
    end
    chk("spur_no_claim", {31'h0, seen}, 32'h0);
    chk("spur_cnt", {24'h0, spur}, 32'h1);
    chk("spur_idle", {29'h0, dbg}, {29'h0, IDLE});
    int_i = 1'b0;
    @(negedge clk);
    chk("spur_stay_idle", {29'h0, dbg}, {29'h0, IDLE});

    // Three-cycle stall on the pending read adds three cycles of latency.
    ctl_load(32'h10, 32'h10);
    exp_q.push_back(5'd4);
    run_claim(3, lat);
    chk("lat_stall", lat, 10);
    accept_claim();

    // Core holds off for five cycles; i_int raised meanwhile is ignored,
    // then starts a fresh claim right after acceptance.
    ctl_load(32'h60, 32'h60);
    exp_q.push_back(5'd5);
    run_claim(0, lat);
    chk("lat_hold", lat, 7);
    rc    = req_cnt;
    int_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, claim_valid}, 32'h1);
      chk("hold_id", {27'h0, claim_id}, 32'd5);
    end
    chk("hold_no_req", req_cnt, rc);
    chk("hold_state", {29'h0, dbg}, {29'h0, PRESENT});
    accept_claim();
    chk("back_idle", {29'h0, dbg}, {29'h0, IDLE});
    @(negedge clk);
    chk("reclaim_start", {29'h0, dbg}, {29'h0, RD_PEND});
    int_i = 1'b0;
    exp_q.push_back(5'd6);
    wait_claim();
    accept_claim();

    // Reset during CLR: valid drops at once, pending bit survives, and the
    // source is claimed again after release.
    ctl_load(32'h80, 32'h80);
    int_i = 1'b1;
    @(negedge clk);
    int_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (dbg == CLR) break;
      @(negedge clk);
    end
    chk("reach_clr", {29'h0, dbg}, {29'h0, CLR});
    mem_ready = 1'b0;
    chk("clr_valid", {31'h0, bus.valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drop_valid", {31'h0, bus.valid}, 32'h0);
    chk("rst_mid_state", {29'h0, dbg}, {29'h0, IDLE});
    chk("rst_mid_spur", {24'h0, spur}, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    chk("pend_kept", m_pend, 32'h80);
    exp_q.push_back(5'd7);
    run_claim(0, lat);
    chk("lat_after_rst", lat, 7);
    accept_claim();
    chk("pend_cleared", m_pend, 32'h0);

    // 260 spurious attempts back to back (6 cycles each) saturate at FF.
    ctl_load(32'h0, 32'h0);
    int_i = 1'b1;
    for (int k = 1; k <= 1560; k++) begin
      @(negedge clk);
      if (k == 1524) chk("spur_254", {24'h0, spur}, 32'hFE);
      if (k == 1530) chk("spur_255", {24'h0, spur}, 32'hFF);
    end
    chk("spur_sat", {24'h0, spur}, 32'hFF);
    chk("spur_sat_idle", {29'h0, dbg}, {29'h0, IDLE});
    int_i = 1'b0;
    @(negedge clk);
    chk("final_idle", {29'h0, dbg}, {29'h0, IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_claim_sequencer.md
INT_CLAIM_SEQUENCER -- requirements
Module: int_claim_sequencer

Interface
REQ-001 SHALL have parameter NUM_INT_SRCS, default 8, giving the number of interrupt sources; legal range 1..32, with elaboration error otherwise.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the word-aligned base of the interrupt controller register window.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_int, input, 1 bit: level interrupt request from the controller's o_int.
REQ-006 SHALL have port if_mem, mem_if initiator: drives valid, w_en, addr, w_data; samples ready, r_data.
REQ-007 SHALL have port o_claim_valid, output, 1 bit: claimed interrupt ID is presented.
REQ-008 SHALL have port o_claim_id, output, 5 bits: index of the claimed source.
REQ-009 SHALL have port i_claim_ready, input, 1 bit: the core accepts the claim.
REQ-010 SHALL have port o_spurious_cnt, output, 8 bits: count of claim attempts that found no enabled pending source.

Function
REQ-011 SHALL implement FSM states IDLE, RD_PEND, WT_PEND, RD_EN, WT_EN, DECIDE, CLR, PRESENT.
REQ-012 SHALL go IDLE -> RD_PEND when i_int=1; otherwise it SHALL stay in IDLE.
REQ-013 In RD_PEND it SHALL drive valid=1, w_en=0, addr=BASE_ADDR+4, and SHALL hold these until ready=1; the request is accepted in the cycle where valid&&ready.
REQ-014 Read data SHALL be sampled from r_data exactly one cycle after acceptance (WT_PEND), giving a fixed registered read latency of 1.
REQ-015 RD_EN/WT_EN SHALL repeat the RD_PEND/WT_PEND sequence at addr=BASE_ADDR+0, capturing the enable mask.
REQ-016 DECIDE SHALL compute masked = pend[NUM_INT_SRCS-1:0] & en[NUM_INT_SRCS-1:0] and select the lowest set index, so that index 0 has the highest priority.
REQ-017 If masked==0, DECIDE SHALL increment o_spurious_cnt (saturating at 8'hFF) and return to IDLE.
REQ-018 Otherwise, DECIDE SHALL latch the selected ID and go to CLR.
REQ-019 CLR SHALL drive valid=1, w_en=1, addr=BASE_ADDR+4, w_data=one-hot(ID) zero-extended to 32 bits, holding until ready=1, then go to PRESENT.
REQ-020 PRESENT SHALL assert o_claim_valid with o_claim_id stable until i_claim_ready=1, then SHALL return to IDLE in the same edge.
REQ-021 valid SHALL be 0 in all states other than RD_PEND, RD_EN and CLR; w_data and w_en are don't-care when valid=0.
REQ-022 Changes in i_int after leaving IDLE SHALL be ignored until the FSM is back in IDLE; a still-asserted i_int SHALL start a new claim on the next cycle.
REQ-023 Minimum claim latency, measured from i_int sampled high to o_claim_valid, SHALL be 7 cycles when ready=1 throughout.
REQ-024 o_claim_id upper bits beyond clog2(NUM_INT_SRCS) SHALL be 0.

Reset
REQ-025 While i_rst=1, the block SHALL be in IDLE with valid=0, o_claim_valid=0, o_claim_id=0, o_spurious_cnt=0, and captured pending/enable registers equal to 0.
REQ-026 Reset asserted mid-transaction SHALL drop valid asynchronously and abort the transaction; an aborted CLR leaves the controller's pending bit set, so the source is re-claimed after reset.

Structure
REQ-027 Register offsets (ENABLE=0, PENDING=4) and the FSM state enum SHALL live in shared package int_ctl_pkg, which the controller also uses.
REQ-028 The lowest-set-bit selection SHALL be a sub-module int_prio_enc (parameter WIDTH; outputs found and index), purely combinational.

Verification
REQ-029 With NUM_INT_SRCS=8 and the controller holding en=8'h0C and pending=8'h0C, pulsing i_int SHALL produce o_claim_id=2, a write of 32'h4 to offset 4, and pending then reading 8'h08.
REQ-030 With en=8'h01 and pending=8'h02 (i_int forced 1), the bench SHALL see no o_claim_valid, o_spurious_cnt increments to 1, and the FSM returns to IDLE.
REQ-031 With ready held 0 for 3 cycles during RD_PEND, addr/valid SHALL stay stable, and latency SHALL grow by exactly 3 cycles.
REQ-032 With i_claim_ready held 0 for 5 cycles in PRESENT, o_claim_valid/o_claim_id SHALL stay stable, and no new if_mem request SHALL be issued.
REQ-033 Asserting i_rst during CLR SHALL drop valid that cycle; after release with en=pending=8'h80, the bench SHALL see o_claim_id=7 claimed again.
REQ-034 After 260 spurious attempts, o_spurious_cnt SHALL equal 8'hFF.
